lieat_axi_sram: RTL
===================

Name: lieat_axi_sram

Overview:
AXI4 slave memory that sits directly downstream of the core's io_master_* port. It serves instruction fetch and load/store traffic from the core's AXI master in simulation and FPGA bring-up. Read and write channels run independent state machines. Storage is a word-addressed internal array with a configurable read latency.

Parameters:
- ADDR_BASE, 32'h8000_0000, first byte address served.
- DEPTH_WORDS, 4096, number of 32-bit words; must be a power of two.
- READ_LAT, 1, idle cycles between AR acceptance and the first R beat; range 0..15.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- awvalid/awready  in/out  1/1  write address handshake.
- awaddr  in  32  write start byte address.
- awid  in  4  write transaction ID.
- awlen  in  8  write beats minus 1.
- awsize  in  3  bytes per beat, log2; 0..2 supported.
- awburst  in  2  burst type: 00 FIXED, 01 INCR; other values are treated as INCR.
- wvalid/wready  in/out  1/1  write data handshake.
- wdata  in  32  write data.
- wstrb  in  8  byte enables; bits [3:0] are used and [7:4] are ignored.
- wlast  in  1  last write beat.
- bvalid/bready  out/in  1/1  write response handshake.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bid  out  4  echoed awid.
- arvalid/arready  in/out  1/1  read address handshake.
- araddr  in  32  read start byte address.
- arid  in  4  read transaction ID.
- arlen  in  8  read beats minus 1.
- arsize  in  3  bytes per beat, log2.
- arburst  in  2  burst type, same encoding as awburst.
- rvalid/rready  out/in  1/1  read data handshake.
- rdata  out  32  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rlast  out  1  last read beat.
- rid  out  4  echoed arid.

Behaviour:
- Reset (rstn low, asynchronous):
  - Both FSMs return to IDLE.
  - awready=1, arready=1.
  - wready, bvalid, rvalid, rlast = 0.
  - bresp, rresp, bid, rid, rdata = 0.
  - Array contents are not reset.
  - Reset mid-burst abandons the burst; no partial response is issued afterwards.
- Word index = (addr - ADDR_BASE) >> 2.
  - An address is in range when ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS.
  - Range is checked per beat.
- Address advance after each beat:
  - INCR: addr += (1 << size).
  - FIXED: addr is unchanged.
  - Arithmetic is 32-bit and wraps at 2^32. A wrapped address falls out of range and becomes SLVERR.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, latch addr/id/len/burst/size, clear beat_cnt, load lat_cnt=READ_LAT. Next state is R_WAIT, or R_DATA if READ_LAT=0.
  - R_WAIT: arready=0. Decrement lat_cnt; enter R_DATA when it reaches 1, so the first rvalid is exactly READ_LAT+1 cycles after AR acceptance.
  - R_DATA: rvalid=1; rdata = mem[index] (full word, no lane shifting); rid = latched id; rlast = (beat_cnt==len).
  - Out-of-range beat: rdata=0, rresp=10; otherwise rresp=00.
  - rdata/rresp/rlast stay stable while rvalid&!rready.
  - On rvalid&rready: advance addr and increment beat_cnt. If rlast, go to R_IDLE (arready rises the next cycle).
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch fields and go to W_DATA.
  - W_DATA: wready=1. On wvalid&wready, write bytes i where wstrb[i]=1 (in range only), then advance addr and beat_cnt.
  - An error flag is sticky for the burst and is set by:
    - any out-of-range beat;
    - wlast=1 when beat_cnt!=len;
    - wlast=0 when beat_cnt==len.
  - The burst ends when beat_cnt==len or wlast=1, whichever comes first; go to W_RESP.
  - W_RESP: bvalid=1; bresp = error ? 10 : 00; bid = latched id. On bready, go to W_IDLE.
- Write data arriving before AW is not accepted: wready=0 outside W_DATA.
- Same-cycle read beat and write to the same word: the read returns the pre-write value; the write lands at the clock edge.
- The read and write FSMs never stall each other. There is no ID-based reordering; at most one outstanding transaction per direction.

Test Plan:
- Single write then read: AW addr=0x8000_0010 len=0 size=2, W data=0xDEADBEEF strb=F → bresp=00, bid echoed. AR to the same address → rdata=0xDEADBEEF, rlast=1, rresp=00, first rvalid 2 cycles after AR acceptance (READ_LAT=1).
- Partial strobe: 0x11223344 written with strb=F, then 0xAABBCCDD with strb=0101 → read returns 0x11BB33DD.
- INCR burst: write 4 beats len=3 at 0x8000_0100, values 1..4; read back len=3 with rready toggling every other cycle → data 1,2,3,4 in order, stable while stalled, rlast only on the 4th beat. A FIXED burst of len=3 writes only 0x8000_0100, which finally holds 4.
- Errors:
  - Read at 0x7FFF_FFFC → rdata=0, rresp=10.
  - Write len=3 with wlast asserted on beat 2 → burst ends, bresp=10, beats 0..1 written.
  - Write at ADDR_BASE+4*DEPTH_WORDS → bresp=10, memory unchanged.
- Concurrency: AR and AW accepted in the same cycle → both complete. A read of a word written in the same cycle returns the old value.
- Async reset: assert rstn low mid read burst (beat 1 of 4) and mid W_DATA → rvalid/wready drop immediately, awready=arready=1 after release, no stray bvalid/rvalid, and a new transaction completes normally.

Source files
------------

// File: rtl/lieat_axi_sram.sv
// AXI4 slave SRAM with independent read/write FSMs, per-beat range checking and a
// configurable read latency. Read data is fetched into a register so it stays stable under stall.
module lieat_axi_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  // write address
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // write data
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  // write response
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  // read address
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // read data
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  // A burst that has carried past 2^32 is out of range even if the wrapped address is not.
  function automatic logic in_range(logic [31:0] addr, logic wrapped);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return !wrapped && ({1'b0, off} < SpanBytes);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return off[IdxW+1:2];
  endfunction

  // Bit 32 of the result is the carry out of the 32-bit address.
  function automatic logic [32:0] next_addr(logic [31:0] addr, logic [1:0] burst, logic [2:0] size);
    if (burst == 2'b00) return {1'b0, addr};
    return {1'b0, addr} + (33'd1 << size);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic        r_wrap_q, r_wrap_d;
  logic [3:0]  r_id_q, r_id_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [7:0]  r_beat_q, r_beat_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [2:0]  r_size_q, r_size_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic [32:0] r_adv;

  logic            fetch;
  logic [31:0]     f_addr;
  logic            f_wrap;
  logic [7:0]      f_beat;
  logic [7:0]      f_len;
  logic            f_hit;
  logic [IdxW-1:0] f_idx;

  assign f_hit = in_range(f_addr, f_wrap);
  assign f_idx = word_idx(f_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_wrap_q  <= 1'b0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
      r_size_q  <= '0;
      lat_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_wrap_q  <= r_wrap_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_burst_q <= r_burst_d;
      r_size_q  <= r_size_d;
      lat_q     <= lat_d;
      // Fetching at the edge means a write landing on the same edge is not seen.
      if (fetch) begin
        rdata_q <= f_hit ? mem[f_idx] : '0;
        rresp_q <= f_hit ? 2'b00 : 2'b10;
        rlast_q <= (f_beat == f_len);
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_wrap_d  = r_wrap_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_burst_d = r_burst_q;
    r_size_d  = r_size_q;
    lat_d     = lat_q;
    fetch     = 1'b0;
    f_addr    = r_addr_q;
    f_wrap    = r_wrap_q;
    f_beat    = r_beat_q;
    f_len     = r_len_q;
    r_adv     = next_addr(r_addr_q, r_burst_q, r_size_q);
    unique case (r_state_q)
      RIdle: begin
        if (arvalid) begin
          r_addr_d  = araddr;
          r_wrap_d  = 1'b0;
          r_id_d    = arid;
          r_len_d   = arlen;
          r_burst_d = arburst;
          r_size_d  = arsize;
          r_beat_d  = '0;
          lat_d     = 4'(READ_LAT);
          if (READ_LAT == 0) begin
            r_state_d = RData;
            fetch     = 1'b1;
            f_addr    = araddr;
            f_wrap    = 1'b0;
            f_beat    = '0;
            f_len     = arlen;
          end else begin
            r_state_d = RWait;
          end
        end
      end
      RWait: begin
        if (lat_q <= 4'd1) begin
          r_state_d = RData;
          fetch     = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RData: begin
        if (rready) begin
          if (rlast_q) begin
            r_state_d = RIdle;
          end else begin
            r_addr_d = r_adv[31:0];
            r_wrap_d = r_wrap_q | r_adv[32];
            r_beat_d = r_beat_q + 8'd1;
            fetch    = 1'b1;
            f_addr   = r_addr_d;
            f_wrap   = r_wrap_d;
            f_beat   = r_beat_d;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic        w_wrap_q, w_wrap_d;
  logic [3:0]  w_id_q, w_id_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [7:0]  w_beat_q, w_beat_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [2:0]  w_size_q, w_size_d;
  logic        w_err_q, w_err_d;
  logic [32:0] w_adv;
  logic        w_hit;
  logic        w_end;
  logic        mem_we;
  logic [IdxW-1:0] w_idx;

  assign w_hit = in_range(w_addr_q, w_wrap_q);
  assign w_idx = word_idx(w_addr_q);
  assign w_end = (w_beat_q == w_len_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= WIdle;
      w_addr_q  <= '0;
      w_wrap_q  <= 1'b0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
      w_size_q  <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_wrap_q  <= w_wrap_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_burst_q <= w_burst_d;
      w_size_q  <= w_size_d;
      w_err_q   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_wrap_d  = w_wrap_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_burst_d = w_burst_q;
    w_size_d  = w_size_q;
    w_err_d   = w_err_q;
    w_adv     = next_addr(w_addr_q, w_burst_q, w_size_q);
    unique case (w_state_q)
      WIdle: begin
        if (awvalid) begin
          w_addr_d  = awaddr;
          w_wrap_d  = 1'b0;
          w_id_d    = awid;
          w_len_d   = awlen;
          w_burst_d = awburst;
          w_size_d  = awsize;
          w_beat_d  = '0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (wvalid) begin
          // wlast must coincide exactly with the final counted beat.
          if (!w_hit || (wlast != w_end)) w_err_d = 1'b1;
          if (wlast || w_end) begin
            w_state_d = WResp;
          end else begin
            w_addr_d = w_adv[31:0];
            w_wrap_d = w_wrap_q | w_adv[32];
            w_beat_d = w_beat_q + 8'd1;
          end
        end
      end
      WResp: begin
        if (bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs and storage
  // ---------------------------------------------------------------------------
  always_comb begin
    arready = (r_state_q == RIdle);
    rvalid  = (r_state_q == RData);
    rlast   = rvalid & rlast_q;
    awready = (w_state_q == WIdle);
    wready  = (w_state_q == WData);
    bvalid  = (w_state_q == WResp);
    bresp   = (bvalid && w_err_q) ? 2'b10 : 2'b00;
    mem_we  = wready & wvalid & w_hit;
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rid   = r_id_q;
  assign bid   = w_id_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic unused_wstrb;
  assign unused_wstrb = ^wstrb[7:4];

endmodule
